// File: rtl/jtag_param_dr.sv
// -----------------------------------------------------------------------------
// jtag_param_dr
//
// Configurable-width JTAG test data register. It sits beside the TAP controller
// and the instruction register. Its serial output feeds the TDO mux.
//
// Two instructions select this register:
//   IR_READ : Capture-DR loads capture_data. Use this for identification or
//             status.
//   IR_RW   : Capture-DR reads back dr_out. A valid Update-DR copies the
//             shifted word into dr_out. An update is valid only when exactly
//             WIDTH Shift-DR edges happened since the Capture-DR.
//
// Ports
//   TCK          : test clock; all state changes on posedge
//   TRST         : synchronous, active-high reset
//   TDI          : serial data in
//   tap_state    : current TAP controller state
//   IR           : current instruction
//   capture_data : parallel value captured under IR_READ
//   dr_tdo       : serial out, always equal to shift[0] (combinational)
//   dr_out       : shadow register, written only by a valid IR_RW update
//   update_pulse : high for the one TCK cycle that follows a valid update
//   len_error    : sticky flag, set by an IR_RW Update-DR with a wrong shift
//                  count
//   selected     : high when IR is IR_READ or IR_RW; used by the TDO mux
// -----------------------------------------------------------------------------
module jtag_param_dr #(
  parameter int                     WIDTH         = 32,
  parameter int                     IR_WIDTH      = 4,
  parameter logic [IR_WIDTH-1:0]    IR_READ       = 'h1,
  parameter logic [IR_WIDTH-1:0]    IR_RW         = 'h2,
  parameter logic [WIDTH-1:0]       RESET_VAL     = WIDTH'(32'hDEADBEEF),
  parameter logic [3:0]             ST_CAPTURE_DR = 4'd3,
  parameter logic [3:0]             ST_SHIFT_DR   = 4'd4,
  parameter logic [3:0]             ST_UPDATE_DR  = 4'd8
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic [3:0]          tap_state,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic [WIDTH-1:0]    capture_data,
  output logic                dr_tdo,
  output logic [WIDTH-1:0]    dr_out,
  output logic                update_pulse,
  output logic                len_error,
  output logic                selected
);

  // The counter must represent 0..WIDTH+1. It saturates at WIDTH+1 instead of
  // wrapping, so any over-length shift stays distinguishable from WIDTH.
  localparam int             CNT_W   = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH + 1);

  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] cnt;

  logic sel_read;
  logic sel_rw;
  logic in_capture;
  logic in_shift;
  logic in_update;
  logic valid_update;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    sel_read     = 1'b0;
    sel_rw       = 1'b0;
    in_capture   = 1'b0;
    in_shift     = 1'b0;
    in_update    = 1'b0;
    valid_update = 1'b0;

    sel_read     = (IR == IR_READ);
    sel_rw       = (IR == IR_RW);
    in_capture   = (tap_state == ST_CAPTURE_DR);
    in_shift     = (tap_state == ST_SHIFT_DR);
    in_update    = (tap_state == ST_UPDATE_DR);
    valid_update = sel_rw && in_update && (cnt == CNT_LEN);
  end

  assign selected = sel_read | sel_rw;
  assign dr_tdo   = shift[0];

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples values from before the edge, whatever order the statements are in.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      // TRST is sampled on the clock edge. A reset in the middle of a shift
      // discards the partial word, and dr_out is not updated.
      shift        <= RESET_VAL;
      dr_out       <= RESET_VAL;
      cnt          <= '0;
      update_pulse <= 1'b0;
      len_error    <= 1'b0;
    end else begin
      // The pulse is derived directly from this edge's update condition. It is
      // cleared on every other edge, including edges where IR is not selected.
      update_pulse <= valid_update;

      if (selected) begin
        if (in_capture) begin
          shift <= sel_read ? capture_data : dr_out;
          cnt   <= '0;
          // A new IR_RW transfer starts with a clean error flag.
          if (sel_rw) begin
            len_error <= 1'b0;
          end
        end else if (in_shift) begin
          shift <= {TDI, shift[WIDTH-1:1]};
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end else if (in_update && sel_rw) begin
          if (cnt == CNT_LEN) begin
            dr_out <= shift;
          end else begin
            len_error <= 1'b1;
          end
        end
        // Pause-DR, Exit-DR and other states: shift, cnt and dr_out hold.
      end
    end
  end

endmodule

// File: tb/tb_jtag_param_dr.sv
// -----------------------------------------------------------------------------
// tb_jtag_param_dr
//
// Self-checking bench for jtag_param_dr with its default parameters.
// The reference model treats the data register as a bit queue. Its front
// element is the TDO bit. A shift pops the front and appends TDI at the back.
// The model also counts the shifts made since the last capture. The bench
// first runs directed sequences, then randomized transactions and random
// tap_state noise.
// -----------------------------------------------------------------------------
module tb_jtag_param_dr;

  localparam int         W         = 32;
  localparam logic [3:0] IR_READ   = 4'h1;
  localparam logic [3:0] IR_RW     = 4'h2;
  localparam logic [3:0] IR_OTHER  = 4'hF;
  localparam logic [3:0] ST_CAP    = 4'd3;
  localparam logic [3:0] ST_SHIFT  = 4'd4;
  localparam logic [3:0] ST_PAUSE  = 4'd6;
  localparam logic [3:0] ST_UPDATE = 4'd8;
  localparam logic [3:0] ST_IDLE   = 4'd1;
  localparam logic [31:0] RST_WORD = 32'hDEADBEEF;

  logic          TCK = 1'b0;
  logic          TRST = 1'b1;
  logic          TDI = 1'b0;
  logic [3:0]    tap_state = ST_IDLE;
  logic [3:0]    IR = IR_OTHER;
  logic [W-1:0]  capture_data = '0;
  logic          dr_tdo;
  logic [W-1:0]  dr_out;
  logic          update_pulse;
  logic          len_error;
  logic          selected;

  jtag_param_dr dut (
    .TCK          (TCK),
    .TRST         (TRST),
    .TDI          (TDI),
    .tap_state    (tap_state),
    .IR           (IR),
    .capture_data (capture_data),
    .dr_tdo       (dr_tdo),
    .dr_out       (dr_out),
    .update_pulse (update_pulse),
    .len_error    (len_error),
    .selected     (selected)
  );

  always #5 TCK = ~TCK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit       mq[$];      // register contents; mq[0] drives TDO
  bit [31:0] m_dr;
  int       m_count;    // shifts since last capture, capped at W+1
  bit       m_pulse;
  bit       m_err;

  function automatic void load_queue(input bit [31:0] v);
    mq.delete();
    for (int i = 0; i < W; i++) mq.push_back(v[i]);
  endfunction

  function automatic bit [31:0] queue_word();
    bit [31:0] w;
    for (int i = 0; i < W; i++) w[i] = mq[i];
    return w;
  endfunction

  function automatic void model_edge(input logic trst, input logic [3:0] st,
                                     input logic [3:0] ir, input logic tdi,
                                     input logic [31:0] cap);
    bit is_r, is_w;
    if (trst) begin
      load_queue(RST_WORD);
      m_dr = RST_WORD; m_count = 0; m_pulse = 0; m_err = 0;
      return;
    end
    is_r = (ir == IR_READ);
    is_w = (ir == IR_RW);
    m_pulse = 0;
    if (!(is_r || is_w)) return;
    if (st == ST_CAP) begin
      load_queue(is_r ? cap : m_dr);
      m_count = 0;
      if (is_w) m_err = 0;
    end else if (st == ST_SHIFT) begin
      void'(mq.pop_front());
      mq.push_back(tdi);
      if (m_count < W + 1) m_count++;
    end else if (st == ST_UPDATE && is_w) begin
      if (m_count == W) begin
        m_dr = queue_word();
        m_pulse = 1;
      end else begin
        m_err = 1;
      end
    end
  endfunction

  // Runs one TCK cycle. Inputs are driven on the falling edge. The model steps
  // on the rising edge. All outputs are compared 1 time unit after that edge.
  task automatic step(input logic trst, input logic [3:0] st, input logic [3:0] ir,
                      input logic tdi, input logic [31:0] cap);
    @(negedge TCK);
    TRST = trst; tap_state = st; IR = ir; TDI = tdi; capture_data = cap;
    #1;
    check("selected", 64'(selected), 64'((ir == IR_READ) || (ir == IR_RW)));
    @(posedge TCK);
    model_edge(trst, st, ir, tdi, cap);
    #1;
    check("dr_tdo", 64'(dr_tdo), 64'(mq[0]));
    check("dr_out", 64'(dr_out), 64'(m_dr));
    check("update_pulse", 64'(update_pulse), 64'(m_pulse));
    check("len_error", 64'(len_error), 64'(m_err));
  endtask

  task automatic idle(input logic [3:0] ir);
    step(1'b0, ST_IDLE, ir, 1'b0, $urandom);
  endtask

  task automatic capture(input logic [3:0] ir, input logic [31:0] cap);
    step(1'b0, ST_CAP, ir, 1'b0, cap);
  endtask

  task automatic update(input logic [3:0] ir);
    step(1'b0, ST_UPDATE, ir, 1'b0, $urandom);
  endtask

  // Shifts n bits (n <= 64) of data, LSB first. The TDO bit present before
  // each shift edge is collected into seen.
  task automatic shift_bits(input logic [3:0] ir, input logic [63:0] data, input int n,
                            output logic [63:0] seen);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      seen[i] = dr_tdo;
      step(1'b0, ST_SHIFT, ir, data[i], $urandom);
    end
  endtask

  logic [63:0] seen;
  logic [31:0] wr;

  initial begin
    // Reset for two cycles.
    step(1'b1, ST_IDLE, IR_READ, 1'b0, '0);
    step(1'b1, ST_IDLE, IR_RW, 1'b0, '0);
    check("rst_dr_out", 64'(dr_out), 64'(RST_WORD));
    check("rst_tdo", 64'(dr_tdo), 64'd1);
    check("rst_pulse", 64'(update_pulse), 64'd0);
    check("rst_len_err", 64'(len_error), 64'd0);

    // IR_READ: capture, 32 shifts, then Update-DR has no effect.
    capture(IR_READ, 32'h1234_5677);
    shift_bits(IR_READ, 64'd0, W, seen);
    check("read_stream", seen[31:0], 64'h1234_5677);
    update(IR_READ);
    check("read_no_upd", 64'(dr_out), 64'(RST_WORD));

    // IR_RW write, then readback.
    capture(IR_RW, $urandom);
    shift_bits(IR_RW, 64'hA5A5_0F0F, W, seen);
    check("rw_old_readback", seen[31:0], 64'(RST_WORD));
    update(IR_RW);
    check("rw_dr_out", 64'(dr_out), 64'hA5A5_0F0F);
    check("rw_pulse_hi", 64'(update_pulse), 64'd1);
    idle(IR_RW);
    check("rw_pulse_lo", 64'(update_pulse), 64'd0);
    capture(IR_RW, $urandom);
    shift_bits(IR_RW, 64'hA5A5_0F0F, W, seen);
    check("rw_readback", seen[31:0], 64'hA5A5_0F0F);
    update(IR_RW);

    // Length errors: a short shift, then a 64-bit long shift.
    capture(IR_RW, $urandom);
    shift_bits(IR_RW, 64'h0, W - 1, seen);
    update(IR_RW);
    check("short_err", 64'(len_error), 64'd1);
    check("short_hold", 64'(dr_out), 64'hA5A5_0F0F);
    capture(IR_RW, $urandom);
    check("cap_clears_err", 64'(len_error), 64'd0);
    shift_bits(IR_RW, {$urandom, $urandom}, 2 * W, seen);
    update(IR_RW);
    check("long_err", 64'(len_error), 64'd1);
    check("long_hold", 64'(dr_out), 64'hA5A5_0F0F);

    // TRST during shift bit 10, then Update-DR with no capture.
    capture(IR_RW, $urandom);
    shift_bits(IR_RW, 64'h3FF, 10, seen);
    step(1'b1, ST_SHIFT, IR_RW, 1'b1, $urandom);
    check("trst_mid_dr_out", 64'(dr_out), 64'(RST_WORD));
    check("trst_mid_err", 64'(len_error), 64'd0);
    update(IR_RW);
    check("trst_upd_err", 64'(len_error), 64'd1);
    check("trst_upd_hold", 64'(dr_out), 64'(RST_WORD));

    // IR change mid-shift: the register stops responding and holds.
    capture(IR_READ, 32'h0000_00F0);
    shift_bits(IR_READ, 64'h0, 4, seen);
    step(1'b0, ST_SHIFT, IR_OTHER, 1'b1, $urandom);
    step(1'b0, ST_SHIFT, IR_OTHER, 1'b0, $urandom);
    check("irchg_sel", 64'(selected), 64'd0);
    check("irchg_hold_tdo", 64'(dr_tdo), 64'd1);

    // Pause between two 16-bit halves still gives a valid transfer.
    wr = $urandom;
    capture(IR_RW, $urandom);
    shift_bits(IR_RW, 64'(wr), 16, seen);
    for (int i = 0; i < 3; i++) step(1'b0, ST_PAUSE, IR_RW, 1'b1, $urandom);
    shift_bits(IR_RW, 64'(wr[31:16]), 16, seen);
    update(IR_RW);
    check("pause_dr_out", 64'(dr_out), 64'(wr));
    check("pause_pulse", 64'(update_pulse), 64'd1);

    // Randomized transactions: shift lengths close to W, optional pauses.
    for (int t = 0; t < 40; t++) begin
      logic [3:0] ir;
      int n;
      ir = ($urandom_range(0, 3) == 0) ? IR_READ : IR_RW;
      case ($urandom_range(0, 4))
        0: n = W - 1;
        1: n = W + 1;
        2: n = $urandom_range(0, 2 * W);
        default: n = W;
      endcase
      capture(ir, $urandom);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) step(1'b0, ST_PAUSE, ir, $urandom, $urandom);
        step(1'b0, ST_SHIFT, ir, 1'($urandom), $urandom);
      end
      update(ir);
      idle(ir);
    end

    // Random noise: any state, any IR, occasional reset.
    for (int t = 0; t < 400; t++) begin
      logic [3:0] st, ir;
      case ($urandom_range(0, 5))
        0: st = ST_CAP;
        1, 2: st = ST_SHIFT;
        3: st = ST_UPDATE;
        default: st = 4'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: ir = IR_READ;
        1, 2: ir = IR_RW;
        default: ir = 4'($urandom);
      endcase
      step(($urandom_range(0, 49) == 0), st, ir, 1'($urandom), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
